// File: rtl/feature_stream_pkg.sv
// Shared types and helpers for the feature stream split/concat blocks.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package feature_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } split_state_e;

    // Words in one frame of h rows, w columns and c channels per pixel.
    function automatic int total_words(input int h, input int w, input int c);
        return h * w * c;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register (data plus valid).
// Latency: a load is visible on data/valid after the next clock edge.
// Backpressure: free = !valid || ready; load and drain may coincide (new data wins).
module stream_out_reg
    import feature_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  free
);

    assign free = !valid || ready;

    // Hold one word until the consumer takes it; a simultaneous load refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/feature_split.sv
// Splits a pixel-major channel-interleaved stream: leading channels to out1, rest to out2.
// Latency: 1 cycle from input handshake to the selected output register.
// Backpressure: input stalls only while the current channel targets a full, unready output.
// Optional: define FEATURE_SPLIT_STATS_EN to add per-port word counters and a mismatch flag.
module feature_split
    import feature_stream_pkg::*;
#(
    parameter int HEIGHT        = 32,
    parameter int WIDTH         = 32,
    parameter int OUT1_CHANNELS = 512,
    parameter int OUT2_CHANNELS = 512,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] feature_in,
    input  logic                  feature_valid_in,
    output logic                  feature_ready_in,
    output logic [DATA_WIDTH-1:0] feature_out1,
    output logic                  feature_valid1,
    input  logic                  feature_ready1,
    output logic [DATA_WIDTH-1:0] feature_out2,
    output logic                  feature_valid2,
    input  logic                  feature_ready2,
    output logic                  busy,
    output logic                  split_done
`ifdef FEATURE_SPLIT_STATS_EN
    ,
    output logic [31:0]           stat_words1,
    output logic [31:0]           stat_words2,
    output logic                  stat_mismatch
`endif
);

    localparam int C     = OUT1_CHANNELS + OUT2_CHANNELS;
    localparam int CH_W  = cnt_width(C);
    localparam int COL_W = cnt_width(WIDTH);
    localparam int ROW_W = cnt_width(HEIGHT);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(C - 1);
    localparam logic [CH_W-1:0]  CH_OUT2  = CH_W'(OUT1_CHANNELS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    // A split with an empty side is meaningless; refuse to elaborate it.
    generate
        if (OUT1_CHANNELS < 1) begin : g_bad_out1
            $error("feature_split: OUT1_CHANNELS must be at least 1");
        end
        if (OUT2_CHANNELS < 1) begin : g_bad_out2
            $error("feature_split: OUT2_CHANNELS must be at least 1");
        end
    endgenerate

    split_state_e    state;
    split_state_e    state_next;
    logic [CH_W-1:0] ch;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic            tgt1;
    logic            free1;
    logic            free2;
    logic            in_hs;
    logic            last_word;

    assign tgt1             = (ch < CH_OUT2);
    assign feature_ready_in = (state == SPLIT) && (tgt1 ? free1 : free2);
    assign in_hs            = feature_valid_in && feature_ready_in;
    assign last_word        = (row == ROW_LAST) && (col == COL_LAST) && (ch == CH_LAST);

    stream_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out1 (
        .clk       (clk),
        .rst       (rst),
        .load      (in_hs && tgt1),
        .load_data (feature_in),
        .data      (feature_out1),
        .valid     (feature_valid1),
        .ready     (feature_ready1),
        .free      (free1)
    );

    stream_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out2 (
        .clk       (clk),
        .rst       (rst),
        .load      (in_hs && !tgt1),
        .load_data (feature_in),
        .data      (feature_out2),
        .valid     (feature_valid2),
        .ready     (feature_ready2),
        .free      (free2)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs; DRAIN waits for both output registers to empty.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        split_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SPLIT;
            end
            SPLIT: begin
                busy = 1'b1;
                if (in_hs && last_word) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!feature_valid1 && !feature_valid2) state_next = DONE;
            end
            DONE: begin
                split_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Position counters: channel fastest, then column, then row; move only on accepted words.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (in_hs) begin
            if (ch == CH_LAST) begin
                ch <= '0;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

`ifdef FEATURE_SPLIT_STATS_EN
    localparam logic [31:0] EXP_WORDS1 = 32'(total_words(HEIGHT, WIDTH, OUT1_CHANNELS));
    localparam logic [31:0] EXP_WORDS2 = 32'(total_words(HEIGHT, WIDTH, OUT2_CHANNELS));

    // Saturating per-port handshake counters, checked against the frame size at completion.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            stat_words1   <= '0;
            stat_words2   <= '0;
            stat_mismatch <= 1'b0;
        end else begin
            if (feature_valid1 && feature_ready1 && stat_words1 != '1)
                stat_words1 <= stat_words1 + 32'd1;
            if (feature_valid2 && feature_ready2 && stat_words2 != '1)
                stat_words2 <= stat_words2 + 32'd1;
            if (state == DONE)
                stat_mismatch <= (stat_words1 != EXP_WORDS1) || (stat_words2 != EXP_WORDS2);
        end
    end
`endif

endmodule

// File: tb/tb_feature_split.sv
// Randomized bench for feature_split against a channel-index reference model.
// Latency: checks each accepted word lands on its output one cycle later.
// Backpressure: scripted and random ready patterns on both outputs.
module tb_feature_split;

    localparam int H  = 2;
    localparam int W  = 2;
    localparam int O1 = 3;
    localparam int O2 = 2;
    localparam int C  = O1 + O2;
    localparam int N  = H * W * C;
    localparam int DW = 16;

    localparam int M_FULL  = 0;
    localparam int M_BP    = 1;
    localparam int M_DRAIN = 2;
    localparam int M_SPUR  = 3;
    localparam int M_RAND  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] feature_in;
    logic          feature_valid_in;
    logic          feature_ready_in;
    logic [DW-1:0] feature_out1;
    logic          feature_valid1;
    logic          feature_ready1;
    logic [DW-1:0] feature_out2;
    logic          feature_valid2;
    logic          feature_ready2;
    logic          busy;
    logic          split_done;
`ifdef FEATURE_SPLIT_STATS_EN
    logic [31:0]   stat_words1;
    logic [31:0]   stat_words2;
    logic          stat_mismatch;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int first_out1;

    feature_split #(
        .HEIGHT(H), .WIDTH(W), .OUT1_CHANNELS(O1), .OUT2_CHANNELS(O2), .DATA_WIDTH(DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .feature_in       (feature_in),
        .feature_valid_in (feature_valid_in),
        .feature_ready_in (feature_ready_in),
        .feature_out1     (feature_out1),
        .feature_valid1   (feature_valid1),
        .feature_ready1   (feature_ready1),
        .feature_out2     (feature_out2),
        .feature_valid2   (feature_valid2),
        .feature_ready2   (feature_ready2),
        .busy             (busy),
        .split_done       (split_done)
`ifdef FEATURE_SPLIT_STATS_EN
        ,
        .stat_words1      (stat_words1),
        .stat_words2      (stat_words2),
        .stat_mismatch    (stat_mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame of words base..base+N-1 under the given ready/valid pattern.
    task automatic run_frame(input int base, input int mode);
        int exp1[$];
        int exp2[$];
        int got1[$];
        int got2[$];
        int i = 0, cyc = 0, bp = 0, hold = 0;
        int fin_cyc = -1, done_cyc = -1, last_out = -1, done_n = 0, in_hs = 0;
        int bp_n = 0, drain_n = 0, pend_tgt = 0, pend_dat = 0;
        bit bp_armed = 0, hold_armed = 0, pend = 0;

        // Reference: word k goes to out1 iff its channel index k mod C is below O1.
        for (int k = 0; k < N; k++) begin
            if ((k % C) < O1) exp1.push_back((base + k) & 16'hFFFF);
            else              exp2.push_back((base + k) & 16'hFFFF);
        end

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;

        while (cyc < 600) begin
            feature_valid_in = (i < N) && ((mode == M_RAND) ? ($urandom_range(0, 3) != 0) : 1'b1);
            feature_in       = DW'(base + i);
            feature_ready1   = 1'b1;
            feature_ready2   = 1'b1;
            if (mode == M_BP && i == 3 && !bp_armed) begin bp_armed = 1; bp = 5; end
            if (bp > 0) begin feature_ready2 = 1'b0; bp--; end
            if (mode == M_DRAIN && i == 18 && !hold_armed) begin hold_armed = 1; hold = 3; end
            if (hold > 0) begin feature_ready1 = 1'b0; hold--; end
            if (mode == M_RAND) begin
                feature_ready1 = 1'($urandom_range(0, 1));
                feature_ready2 = 1'($urandom_range(0, 1));
            end
            start = (mode == M_SPUR) && (i == 8);

            @(negedge clk);
            if (pend) begin
                if (pend_tgt == 1) begin
                    chk("lat_vld1", feature_valid1, 1);
                    chk("lat_dat1", feature_out1, pend_dat);
                end else begin
                    chk("lat_vld2", feature_valid2, 1);
                    chk("lat_dat2", feature_out2, pend_dat);
                end
            end
            pend = 0;
            if (mode == M_BP && i == 4 && !feature_ready2 && feature_valid2) begin
                chk("bp_stall_rdy", feature_ready_in, 0);
                chk("bp_held_w3", feature_out2, (base + 3) & 16'hFFFF);
                bp_n++;
            end
            if (mode == M_DRAIN && fin_cyc >= 0 && feature_valid1) begin
                chk("drain_busy", busy, 1);
                chk("drain_nodone", split_done, 0);
                chk("drain_rdy", feature_ready_in, 0);
                drain_n++;
            end
            if (feature_valid1 && feature_ready1) begin got1.push_back(feature_out1); last_out = cyc; end
            if (feature_valid2 && feature_ready2) begin got2.push_back(feature_out2); last_out = cyc; end
            if (split_done) begin done_n++; done_cyc = cyc; end
            if (feature_valid_in && feature_ready_in) begin
                pend     = 1;
                pend_dat = feature_in;
                pend_tgt = ((i % C) < O1) ? 1 : 2;
                i++;
                in_hs++;
                if (i == N) fin_cyc = cyc;
            end
            cyc++;
            @(posedge clk); #1;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        feature_valid_in = 1'b0;
        start            = 1'b0;

        chk("done_seen", done_cyc >= 0, 1);
        chk("done_once", done_n, 1);
        chk("in_handshakes", in_hs, N);
        // DRAIN sees the last register empty one cycle after its handshake, DONE follows.
        chk("done_delay", done_cyc - last_out, 2);
        chk("n_out1", got1.size(), exp1.size());
        chk("n_out2", got2.size(), exp2.size());
        for (int k = 0; k < exp1.size() && k < got1.size(); k++) chk("out1_word", got1[k], exp1[k]);
        for (int k = 0; k < exp2.size() && k < got2.size(); k++) chk("out2_word", got2[k], exp2[k]);
        if (mode == M_BP)    chk("bp_seen", bp_n > 0, 1);
        if (mode == M_DRAIN) chk("drain_seen", drain_n > 0, 1);
        first_out1 = (got1.size() > 0) ? got1[0] : -1;
        chk("idle_busy", busy, 0);
    endtask

    // Starts a frame, then resets once word 7 has been accepted.
    task automatic reset_mid(input int base);
        int i = 0;
        int guard = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (i < 8 && guard < 100) begin
            feature_valid_in = 1'b1;
            feature_in       = DW'(base + i);
            feature_ready1   = 1'b1;
            feature_ready2   = 1'b1;
            @(negedge clk);
            if (feature_valid_in && feature_ready_in) i++;
            guard++;
            @(posedge clk); #1;
        end
        chk("rstmid_reached", i, 8);
        rst = 1'b1;
        feature_valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_vld1", feature_valid1, 0);
        chk("rstmid_vld2", feature_valid2, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rdy", feature_ready_in, 0);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; feature_in = '0; feature_valid_in = 1'b0;
        feature_ready1 = 1'b1; feature_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld1", feature_valid1, 0);
        chk("rst_vld2", feature_valid2, 0);
        chk("rst_out1", feature_out1, 0);
        chk("rst_out2", feature_out2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", split_done, 0);
        chk("rst_rdy", feature_ready_in, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Words offered while IDLE must not be taken.
        feature_valid_in = 1'b1;
        @(negedge clk);
        chk("idle_rdy", feature_ready_in, 0);
        @(posedge clk); #1 feature_valid_in = 1'b0;

        run_frame(0, M_FULL);
        chk("full_first1", first_out1, 0);
`ifdef FEATURE_SPLIT_STATS_EN
        chk("stat_words1", stat_words1, H * W * O1);
        chk("stat_words2", stat_words2, H * W * O2);
        chk("stat_mismatch", stat_mismatch, 0);
`endif
        run_frame(0, M_BP);
        run_frame(0, M_DRAIN);
        run_frame(0, M_SPUR);
        reset_mid(0);
        run_frame(100, M_FULL);
        chk("fresh_first1", first_out1, 100);
        for (int f = 0; f < 4; f++) run_frame(int'($urandom_range(0, 60000)), M_RAND);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
